// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared constants and divisor clamp helper for the baud tick generator
package baud_pkg;
    localparam int DIV_WIDTH_DEF  = 16;
    localparam int FRAC_WIDTH_DEF = 4;
    localparam int DEFAULT_DIV    = 326;
    localparam int MIN_DIV        = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction
endpackage

// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - control/status bundle between a UART controller and baud_tick_gen
interface baud_tick_gen_if #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4
);
    logic                  i_enable;
    logic                  i_restart;
    logic                  i_div_wr;
    logic [DIV_WIDTH-1:0]  i_div;
    logic [FRAC_WIDTH-1:0] i_frac;
    logic                  o_div_ack;
    logic [DIV_WIDTH-1:0]  o_div_cur;
    logic                  o_os_tck;
    logic                  o_bit_tck;

    modport master (
        output i_enable, i_restart, i_div_wr, i_div, i_frac,
        input  o_div_ack, o_div_cur, o_os_tck, o_bit_tck
    );

    modport slave (
        input  i_enable, i_restart, i_div_wr, i_div, i_frac,
        output o_div_ack, o_div_cur, o_os_tck, o_bit_tck
    );
endinterface

// File: rtl/baud_div_ctrl.sv
// rtl/baud_div_ctrl.sv - pending divisor register, clamp, apply and ack (frac part with BAUD_FRAC_EN)
module baud_div_ctrl #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 326
`ifdef BAUD_FRAC_EN
    ,
    parameter int FRAC_WIDTH  = 4
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  apply,
    input  logic                  div_wr,
    input  logic [DIV_WIDTH-1:0]  div,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_WIDTH-1:0] frac,
    output logic [FRAC_WIDTH-1:0] frac_cur,
`endif
    output logic [DIV_WIDTH-1:0]  div_cur,
    output logic                  div_ack
);
    import baud_pkg::*;

    logic                 pending;
    logic [DIV_WIDTH-1:0] pend_div;
    logic [DIV_WIDTH-1:0] div_clamped;

    assign div_clamped = DIV_WIDTH'(clamp_div(32'(div)));

    // A write coinciding with an apply lands in pend_* while the older value is applied.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pending  <= 1'b0;
            pend_div <= DIV_WIDTH'(DEFAULT_DIV);
            div_cur  <= DIV_WIDTH'(DEFAULT_DIV);
            div_ack  <= 1'b0;
        end else begin
            div_ack <= apply && pending;
            if (apply && pending)
                div_cur <= pend_div;
            if (div_wr) begin
                pend_div <= div_clamped;
                pending  <= 1'b1;
            end else if (apply) begin
                pending  <= 1'b0;
            end
        end
    end

`ifdef BAUD_FRAC_EN
    logic [FRAC_WIDTH-1:0] pend_frac;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pend_frac <= '0;
            frac_cur  <= '0;
        end else begin
            if (apply && pending)
                frac_cur <= pend_frac;
            if (div_wr)
                pend_frac <= frac;
        end
    end
`endif
endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - programmable oversample/bit tick generator; BAUD_FRAC_EN adds a fractional divider
module baud_tick_gen #(
    parameter int DIV_WIDTH   = baud_pkg::DIV_WIDTH_DEF,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = baud_pkg::DEFAULT_DIV,
    parameter int FRAC_WIDTH  = baud_pkg::FRAC_WIDTH_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    baud_tick_gen_if.slave  bus
);
    import baud_pkg::*;

    localparam int BIT_W = $clog2(OVERSAMPLE);

    logic [DIV_WIDTH-1:0] os_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DIV_WIDTH-1:0] div_cur;
    logic                 div_ack;
    logic                 os_tck;
    logic                 bit_tck;
    logic                 wrap;
    logic                 apply;
    logic [DIV_WIDTH:0]   period_last;

`ifdef BAUD_FRAC_EN
    logic [FRAC_WIDTH-1:0] frac_cur;
    logic [FRAC_WIDTH-1:0] acc;
    logic                  stretch;

    // A carry out of the accumulator lengthens the following period by one cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc     <= '0;
            stretch <= 1'b0;
        end else if (bus.i_restart) begin
            acc     <= '0;
            stretch <= 1'b0;
        end else if (wrap) begin
            {stretch, acc} <= {1'b0, acc} + {1'b0, frac_cur};
        end
    end

    assign period_last = {1'b0, div_cur} - (DIV_WIDTH+1)'(1) + (DIV_WIDTH+1)'(stretch);
`else
    logic [FRAC_WIDTH-1:0] unused_frac;

    assign unused_frac = bus.i_frac;
    assign period_last = {1'b0, div_cur} - (DIV_WIDTH+1)'(1);
`endif

    // >= rather than == so a divisor shrunk while disabled cannot overrun the counter.
    assign wrap  = bus.i_enable && !bus.i_restart && ({1'b0, os_cnt} >= period_last);
    assign apply = wrap || !bus.i_enable || bus.i_restart;

    baud_div_ctrl #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
`ifdef BAUD_FRAC_EN
        ,
        .FRAC_WIDTH  (FRAC_WIDTH)
`endif
    ) u_div_ctrl (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .apply    (apply),
        .div_wr   (bus.i_div_wr),
        .div      (bus.i_div),
`ifdef BAUD_FRAC_EN
        .frac     (bus.i_frac),
        .frac_cur (frac_cur),
`endif
        .div_cur  (div_cur),
        .div_ack  (div_ack)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            os_tck  <= 1'b0;
            bit_tck <= 1'b0;
        end else if (bus.i_restart) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            os_tck  <= 1'b0;
            bit_tck <= 1'b0;
        end else if (!bus.i_enable) begin
            os_tck  <= 1'b0;
            bit_tck <= 1'b0;
        end else if (wrap) begin
            os_cnt <= '0;
            os_tck <= 1'b1;
            if (bit_cnt == BIT_W'(OVERSAMPLE - 1)) begin
                bit_cnt <= '0;
                bit_tck <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                bit_tck <= 1'b0;
            end
        end else begin
            os_cnt  <= os_cnt + DIV_WIDTH'(1);
            os_tck  <= 1'b0;
            bit_tck <= 1'b0;
        end
    end

    assign bus.o_os_tck  = os_tck;
    assign bus.o_bit_tck = bit_tck;
    assign bus.o_div_ack = div_ack;
    assign bus.o_div_cur = div_cur;
endmodule
